mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbiter and sequencer for a single shared unified memory port, used by the pipelined 32-bit CPU's instruction-fetch (IF) stage and data-memory (DM/MEM) stage.
- Grants one requester at a time and holds address and data stable until the memory acknowledges.
- Returns read data and a one-cycle ready pulse to the granted requester.
- Produces stall signals the pipeline uses to freeze the IF and MEM stages while they wait.

Parameters:
- ADDR_W, 32, address width, both ports and memory side.
- DATA_W, 32, data width.
- STARVE_LIM, 4, maximum consecutive DM grants while IF is pending before IF is forced a grant; legal range 1..15.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ready.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_rdata  out  DATA_W  fetched word; registered.
- if_ready  out  1  one-cycle pulse: fetch complete, if_rdata valid.
- dm_req  in  1  data request; held high until dm_ready.
- dm_we  in  1  1 = write, 0 = read; stable with dm_req.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_rdata  out  DATA_W  read data; registered.
- dm_ready  out  1  one-cycle pulse: data access complete.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ack = 1.
- mem_ack  in  1  one-cycle completion from memory; may arrive at the earliest 1 cycle after mem_req rises.
- stall_if  out  1  if_req & ~if_ready (combinational).
- stall_mem  out  1  dm_req & ~dm_ready (combinational).

Behaviour:
- Reset (synchronous) clears everything:
  - state = IDLE; streak = 0.
  - mem_req, mem_we, if_ready, dm_ready = 0.
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
  - Reset overrides any in-flight access. An ack arriving after reset is ignored, because mem_ack is ignored in IDLE.
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- Effective requests:
  - if_eff = if_req & ~if_ready
  - dm_eff = dm_req & ~dm_ready
  - Masking stops a requester being granted again in the cycle its ready pulse is visible.
- IDLE arbitration, evaluated each cycle and taking effect at the next edge:
  - Only dm_eff: grant DM.
  - Only if_eff: grant IF.
  - Both, streak < STARVE_LIM: grant DM, streak += 1.
  - Both, streak == STARVE_LIM: grant IF.
  - Any IF grant clears streak to 0. A DM grant with if_eff low also clears streak to 0.
- On grant:
  - mem_req <= 1 and mem_addr <= the granted port's address.
  - For DM: mem_we <= dm_we, mem_wdata <= dm_wdata.
  - For IF: mem_we <= 0; mem_wdata holds its previous value.
  - State moves to BUSY_IF or BUSY_DM.
- BUSY_x:
  - mem_req, mem_we, mem_addr and mem_wdata stay constant until mem_ack.
  - On mem_ack: mem_req <= 0, mem_we <= 0, x_ready <= 1 for exactly one cycle, state <= IDLE.
  - Read data: IF captures if_rdata <= mem_rdata. A DM read captures dm_rdata <= mem_rdata. A DM write leaves dm_rdata unchanged.
- Latency: request high in cycle N (IDLE, granted) -> mem_req high in N+1 -> ack in cycle M >= N+1 -> ready high in M+1.
  - Minimum request-to-ready latency is 2 cycles.
  - The next grant can happen in cycle M+1 (the IDLE cycle in which ready is high), so back-to-back accesses have 2-cycle throughput.
- The ready pulse and the next grant coexist: while x_ready = 1, the other port may be granted.
- Requesters hold their req and operands until they see ready. A requester dropping req before ready is an illegal protocol; its access still completes and its ready still pulses.
- rdata registers hold their value until the next completed read for that port.

Test Plan:
- Reset, then IF-only: if_req=1, if_addr=0x100, mem_ack one cycle after mem_req, mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0; if_ready pulses 2 cycles after request; if_rdata=0xDEADBEEF; stall_if high until ready.
- Simultaneous IF (0x200) and DM read (0x8000) -> DM granted first, dm_rdata = memory value; IF granted in the cycle dm_ready is high; if_ready follows 2 cycles later.
- DM write: dm_we=1, dm_addr=0x40, dm_wdata=0x12345678, ack delayed 3 cycles -> mem_req/mem_addr/mem_wdata/mem_we stable for all 4 busy cycles; dm_ready single pulse; dm_rdata unchanged.
- Starvation, STARVE_LIM=4: dm_req continuously re-asserted and if_req held high -> exactly 4 DM grants, then 1 IF grant, then DM resumes; streak returns to 0.
- Reset mid-access: assert reset while in BUSY_DM, then pulse mem_ack after reset releases -> no dm_ready; mem_req = 0; state IDLE; the stray ack is ignored.
- Back-to-back IF: re-request immediately after if_ready, with ack always one cycle after mem_req -> one completion every 2 cycles; no double grant for a single request.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter for one shared memory port between instruction fetch (IF) and data memory (DM).
// DM wins contention until it has taken STARVE_LIM consecutive grants over a waiting IF.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,

  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,

  output logic              stall_if,
  output logic              stall_mem
);

  localparam logic [3:0] Lim = 4'(STARVE_LIM);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyDm} state_e;

  state_e     state;
  logic [3:0] streak;

  logic if_eff;
  logic dm_eff;
  logic grant_if;
  logic grant_dm;

  // A port whose ready pulse is visible this cycle must not be granted again.
  assign if_eff = if_req & ~if_ready;
  assign dm_eff = dm_req & ~dm_ready;

  assign stall_if  = if_eff;
  assign stall_mem = dm_eff;

  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (state == StIdle) begin
      if (dm_eff && (!if_eff || (streak < Lim))) begin
        grant_dm = 1'b1;
      end else if (if_eff) begin
        grant_if = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= StIdle;
      streak    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      unique case (state)
        StIdle: begin
          if (grant_dm) begin
            state     <= StBusyDm;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            streak    <= if_eff ? (streak + 4'd1) : 4'd0;
          end else if (grant_if) begin
            state    <= StBusyIf;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            streak   <= 4'd0;
          end
        end
        StBusyIf: begin
          if (mem_ack) begin
            state    <= StIdle;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            if_ready <= 1'b1;
            if_rdata <= mem_rdata;
          end
        end
        StBusyDm: begin
          if (mem_ack) begin
            state    <= StIdle;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            dm_ready <= 1'b1;
            if (!mem_we) begin
              dm_rdata <= mem_rdata;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized requesters and memory, scored against
// a transaction-level model of the arbitration and completion rules.
module tb_mem_arbiter;

  localparam int Lim = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_if;
  logic        stall_mem;

  mem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_LIM(Lim)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_ready (dm_ready),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .stall_if (stall_if),
    .stall_mem(stall_mem)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: who owns the memory (0 none, 1 IF, 2 DM) and what each output should read.
  int          e_owner = 0;
  logic        e_mem_req = 1'b0;
  logic        e_we = 1'b0;
  logic [31:0] e_addr = '0;
  logic [31:0] e_wdata = '0;
  logic        e_if_ready = 1'b0;
  logic        e_dm_ready = 1'b0;
  logic [31:0] e_if_rdata = '0;
  logic [31:0] e_dm_rdata = '0;
  int          streak = 0;
  int          ack_wait = 0;
  bit          if_pend = 1'b0;
  bit          dm_pend = 1'b0;

  // Inputs for the coming edge are already driven; check the combinational stalls, advance the
  // model by one edge and compare every registered output.
  task automatic cycle();
    int          n_owner;
    logic        n_mem_req, n_we, n_if_ready, n_dm_ready, ife, dme;
    logic [31:0] n_addr, n_wdata, n_if_rdata, n_dm_rdata;
    #1;
    check("stall_if", stall_if, if_req & ~e_if_ready);
    check("stall_mem", stall_mem, dm_req & ~e_dm_ready);
    n_owner    = e_owner;
    n_mem_req  = e_mem_req;
    n_we       = e_we;
    n_addr     = e_addr;
    n_wdata    = e_wdata;
    n_if_rdata = e_if_rdata;
    n_dm_rdata = e_dm_rdata;
    n_if_ready = 1'b0;
    n_dm_ready = 1'b0;
    if (reset) begin
      n_owner = 0; n_mem_req = 0; n_we = 0; n_addr = '0; n_wdata = '0;
      n_if_rdata = '0; n_dm_rdata = '0; streak = 0;
    end else if (e_owner == 0) begin
      ife = if_req && !e_if_ready;
      dme = dm_req && !e_dm_ready;
      if (dme && (!ife || streak < Lim)) begin
        n_owner = 2; n_mem_req = 1; n_we = dm_we; n_addr = dm_addr; n_wdata = dm_wdata;
        streak = ife ? streak + 1 : 0;
        ack_wait = $urandom_range(0, 3);
      end else if (ife) begin
        n_owner = 1; n_mem_req = 1; n_we = 0; n_addr = if_addr;
        streak = 0;
        ack_wait = $urandom_range(0, 3);
      end
    end else if (mem_ack) begin
      n_owner = 0; n_mem_req = 0; n_we = 0;
      if (e_owner == 1) begin
        n_if_ready = 1; n_if_rdata = mem_rdata;
      end else begin
        n_dm_ready = 1;
        if (!e_we) n_dm_rdata = mem_rdata;
      end
    end
    @(posedge clock);
    #1;
    e_owner = n_owner; e_mem_req = n_mem_req; e_we = n_we; e_addr = n_addr; e_wdata = n_wdata;
    e_if_ready = n_if_ready; e_dm_ready = n_dm_ready;
    e_if_rdata = n_if_rdata; e_dm_rdata = n_dm_rdata;
    check("mem_req", mem_req, e_mem_req);
    check("mem_we", mem_we, e_we);
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wdata);
    check("if_ready", if_ready, e_if_ready);
    check("dm_ready", dm_ready, e_dm_ready);
    check("if_rdata", if_rdata, e_if_rdata);
    check("dm_rdata", dm_rdata, e_dm_rdata);
  endtask

  // Protocol-legal random requesters and a memory with 0..3 wait cycles plus stray idle acks.
  task automatic drive_auto();
    if (e_if_ready) if_pend = 1'b0;
    if (!if_pend && ($urandom % 3 == 0)) begin
      if_pend = 1'b1;
      if_addr = $urandom;
    end
    if_req = if_pend;
    if (e_dm_ready) dm_pend = 1'b0;
    if (!dm_pend && ($urandom % 2 == 0)) begin
      dm_pend  = 1'b1;
      dm_we    = 1'($urandom % 2);
      dm_addr  = $urandom;
      dm_wdata = $urandom;
    end
    dm_req = dm_pend;
    mem_rdata = $urandom;
    if (e_owner != 0) begin
      if (ack_wait == 0) begin
        mem_ack = 1'b1;
      end else begin
        mem_ack = 1'b0;
        ack_wait--;
      end
    end else begin
      mem_ack = ($urandom % 8 == 0);
    end
  endtask

  initial begin
    reset = 1'b1; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0;
    dm_wdata = '0; mem_rdata = '0; mem_ack = 0;
    cycle();
    cycle();
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    reset = 1'b0;
    cycle();

    // IF only, single-cycle ack.
    if_req = 1; if_addr = 32'h100;
    cycle();
    check("t1_addr", mem_addr, 32'h100);
    check("t1_req", mem_req, 1'b1);
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    cycle();
    mem_ack = 0;
    check("t1_ready", if_ready, 1'b1);
    check("t1_rdata", if_rdata, 32'hDEADBEEF);
    if_req = 0;
    cycle();
    check("t1_pulse", if_ready, 1'b0);

    // Simultaneous IF and DM read: DM first, IF granted while dm_ready is visible.
    if_req = 1; if_addr = 32'h200; dm_req = 1; dm_we = 0; dm_addr = 32'h8000;
    cycle();
    check("t2_dm_first", mem_addr, 32'h8000);
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    cycle();
    check("t2_dm_ready", dm_ready, 1'b1);
    check("t2_dm_rdata", dm_rdata, 32'hCAFEF00D);
    dm_req = 0; mem_ack = 0;
    cycle();
    check("t2_if_grant", mem_addr, 32'h200);
    check("t2_if_req", mem_req, 1'b1);
    mem_ack = 1; mem_rdata = 32'h0BADF00D;
    cycle();
    mem_ack = 0;
    check("t2_if_ready", if_ready, 1'b1);
    if_req = 0;
    cycle();

    // DM write with three wait cycles before the ack.
    dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'h12345678;
    cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t3_hold_addr", mem_addr, 32'h40);
      check("t3_hold_wdata", mem_wdata, 32'h12345678);
      check("t3_hold_we", mem_we, 1'b1);
      check("t3_hold_req", mem_req, 1'b1);
      check("t3_no_ready", dm_ready, 1'b0);
    end
    mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    cycle();
    mem_ack = 0;
    check("t3_ready", dm_ready, 1'b1);
    check("t3_rdata_kept", dm_rdata, 32'hCAFEF00D);
    dm_req = 0; dm_we = 0;
    cycle();
    check("t3_pulse", dm_ready, 1'b0);

    // Reset while DM is busy, then a stray ack.
    dm_req = 1; dm_addr = 32'h80;
    cycle();
    reset = 1;
    cycle();
    reset = 0; dm_req = 0; mem_ack = 1; mem_rdata = 32'h55AA55AA;
    cycle();
    mem_ack = 0;
    check("t4_no_ready", dm_ready, 1'b0);
    check("t4_req_low", mem_req, 1'b0);
    check("t4_rdata_clr", dm_rdata, 32'h0);
    cycle();
    check("t4_still_idle", mem_req, 1'b0);

    // IF re-requests as soon as it sees ready; memory acks immediately.
    if_pend = 0;
    for (int i = 0; i < 24; i++) begin
      if (e_if_ready) if_pend = 0;
      if (!if_pend) begin
        if_pend = 1;
        if_addr = 32'h300 + 32'(i * 4);
      end
      if_req = 1;
      mem_ack = (e_owner != 0);
      mem_rdata = $urandom;
      cycle();
    end
    if_req = 0; if_pend = 0;
    for (int i = 0; i < 6; i++) begin
      mem_ack = (e_owner != 0);
      cycle();
    end
    mem_ack = 0;

    // Randomized traffic with one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        reset = 1; if_pend = 0; dm_pend = 0; if_req = 0; dm_req = 0;
        mem_ack = 1'($urandom % 2);
      end else begin
        reset = 0;
        drive_auto();
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
